// File: rtl/uart_pkg.sv
// uart_pkg: frame-format definitions shared by the UART transmitter and receiver.
//   state_e      - transmitter/receiver frame states
//   PAR_EVEN/ODD - encoding of the parity-type select
//   parity_bit() - parity bit from the XOR-reduction of the data and the parity type
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Chooses the parity bit so the data ones plus the parity bit total even or odd.
  function automatic logic parity_bit(input logic data_xor, input logic typ);
    logic p;
    case (typ)
      PAR_EVEN: p = data_xor;
      PAR_ODD:  p = ~data_xor;
      default:  p = data_xor;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: bit-period counter. Counts 0..PRESCALE and wraps, so one bit period
// lasts PRESCALE+1 cycles.
//   CLK      - system clock
//   RST      - synchronous active-high reset
//   load     - restart the period at 0 on the next cycle (frame start)
//   PRESCALE - terminal count for the period
//   bit_done - high in the final cycle of each bit period
module uart_baud_cnt #(
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  load,
  input  logic [PRESCALE_W-1:0] PRESCALE,
  output logic                  bit_done
);

  logic [PRESCALE_W-1:0] cnt_q;

  assign bit_done = (cnt_q == PRESCALE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
    end else if (load || bit_done) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + PRESCALE_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter. Sends start, DATA_WIDTH data bits
// (LSB first), optional parity and 1 or 2 stop bits; valid/ready handshake allows
// back-to-back frames with no idle gap.
//   CLK, RST     - clock, synchronous active-high reset
//   P_DATA       - word to send, captured on accept
//   DATA_VALID   - word available
//   DATA_READY   - word accepted at the next edge if DATA_VALID
//   PAR_EN       - insert parity bit (captured on accept)
//   PAR_TYP      - 0 even, 1 odd parity (captured on accept)
//   STOP2        - two stop bits (captured on accept)
//   PRESCALE     - bit period is PRESCALE+1 cycles (captured on accept)
//   TX_OUT       - registered serial line, idles high
//   Busy         - frame in progress
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  output logic                  DATA_READY,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  input  logic [PRESCALE_W-1:0] PRESCALE,
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int unsigned IDX_W = $clog2(DATA_WIDTH);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [PRESCALE_W-1:0] prescale_q;
  logic [IDX_W-1:0]      bit_idx_q;
  logic                  par_bit_q, par_en_q, stop2_q, stop_idx_q;
  logic                  tx_q, tx_d;
  logic                  ready, accept, bit_done, last_data, last_stop;

  assign accept    = DATA_VALID && ready;
  assign last_data = bit_done && (bit_idx_q == IDX_W'(DATA_WIDTH - 1));
  assign last_stop = bit_done && (stop_idx_q == stop2_q);

  uart_baud_cnt #(
    .PRESCALE_W(PRESCALE_W)
  ) u_baud (
    .CLK      (CLK),
    .RST      (RST),
    .load     (accept),
    .PRESCALE (prescale_q),
    .bit_done (bit_done)
  );

  // State register and frame shadow registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      tx_q       <= 1'b1;
      shift_q    <= '0;
      prescale_q <= '0;
      bit_idx_q  <= '0;
      par_bit_q  <= 1'b0;
      par_en_q   <= 1'b0;
      stop2_q    <= 1'b0;
      stop_idx_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      if (accept) begin
        shift_q    <= P_DATA;
        prescale_q <= PRESCALE;
        par_bit_q  <= parity_bit(^P_DATA, PAR_TYP);
        par_en_q   <= PAR_EN;
        stop2_q    <= STOP2;
        bit_idx_q  <= '0;
        stop_idx_q <= 1'b0;
      end else if (bit_done) begin
        if (state_q == DATA) begin
          shift_q   <= shift_q >> 1;
          bit_idx_q <= bit_idx_q + IDX_W'(1);
        end
        if (state_q == STOP) begin
          stop_idx_q <= ~stop_idx_q;
        end
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = START;
      START:   if (bit_done) state_d = DATA;
      DATA:    if (last_data) state_d = par_en_q ? PARITY : STOP;
      PARITY:  if (bit_done) state_d = STOP;
      STOP:    if (last_stop) state_d = accept ? START : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs. The line value is computed from the next state so TX_OUT, a flop,
  // lines up with the state it belongs to.
  always_comb begin
    ready = (state_q == IDLE) || ((state_q == STOP) && last_stop);
    tx_d  = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      // On a data-bit boundary the register shifts this edge, so bit 1 is next.
      DATA:    tx_d = ((state_q == DATA) && bit_done) ? shift_q[1] : shift_q[0];
      PARITY:  tx_d = par_bit_q;
      default: tx_d = 1'b1;
    endcase
  end

  assign DATA_READY = ready;
  assign TX_OUT     = tx_q;
  assign Busy       = (state_q != IDLE);

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised successor to the UART transmitter. It serialises a DATA_WIDTH-bit word as start, data (LSB first), optional parity and 1 or 2 stop bits. An internal baud prescaler sets the bit period, and a valid/ready handshake allows back-to-back frames with zero idle gap. It sits between the host-side byte source and the serial line, alongside the UART receiver.

Parameters:
DATA_WIDTH, 8, data bits per frame; legal range 5..9.
PRESCALE_W, 8, width of the PRESCALE input.

Ports:
CLK  in  1  single system clock; all logic on rising edge.
RST  in  1  reset; synchronous, active-high.
P_DATA  in  DATA_WIDTH  parallel word to send; sampled on accept.
DATA_VALID  in  1  word available on P_DATA.
DATA_READY  out  1  block can accept a word this cycle.
PAR_EN  in  1  1 = insert a parity bit; sampled on accept.
PAR_TYP  in  1  0 = even parity, 1 = odd parity; sampled on accept.
STOP2  in  1  0 = one stop bit, 1 = two stop bits; sampled on accept.
PRESCALE  in  PRESCALE_W  bit period is PRESCALE+1 CLK cycles; sampled on accept.
TX_OUT  out  1  serial line; registered; idles high.
Busy  out  1  high while a frame is in progress (state != IDLE).

Behaviour:
- Reset (RST=1 at a CLK edge), effective that edge, including mid-frame:
  - state = IDLE; all counters and shadow registers cleared.
  - TX_OUT = 1, Busy = 0, DATA_READY = 1 once RST deasserts.
  - A partial frame is abandoned, not completed.
- Accept rule: a word is taken on a CLK edge where DATA_VALID && DATA_READY.
  - At that edge, P_DATA, PAR_EN, PAR_TYP, STOP2 and PRESCALE are captured into shadow registers.
  - Input changes after the accept edge have no effect on the current frame.
- DATA_READY is high in:
  - IDLE;
  - the final CLK cycle of the last stop bit (back-to-back window).
  - It is low at all other times.
- Latency: accept at edge k -> TX_OUT = 0 (start bit) from edge k+1.
- Bit timing:
  - a bit-cycle counter runs 0..PRESCALE_shadow;
  - the bit advances when the counter equals PRESCALE_shadow;
  - each bit lasts exactly PRESCALE_shadow+1 cycles;
  - PRESCALE = 0 gives one cycle per bit.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on accept.
  - START -> DATA after one bit period.
  - DATA:
    - transmits shift_reg[0] and shifts right each bit period;
    - a bit index counts 0..DATA_WIDTH-1;
    - after the last bit -> PARITY if PAR_EN_shadow, else -> STOP.
  - PARITY:
    - TX_OUT = (^data_shadow) XOR PAR_TYP_shadow, so total ones are even when PAR_TYP=0 and odd when PAR_TYP=1;
    - -> STOP after one bit period.
  - STOP:
    - TX_OUT = 1 for 1 or 2 bit periods, per STOP2_shadow.
    - At the end of the last period: if an accept occurs -> START (no idle cycle); else -> IDLE.
- Frame length = (1 + DATA_WIDTH + PAR_EN + 1 + STOP2) * (PRESCALE+1) cycles exactly.
- Busy = (state != IDLE); it remains high across back-to-back frames.
- DATA_VALID while DATA_READY = 0 is held off (no accept); the source keeps P_DATA stable until accepted.
- No glitches: TX_OUT is driven only from a flop.

Decomposition:
- Package uart_pkg:
  - state enum {IDLE, START, DATA, PARITY, STOP};
  - localparams PAR_EVEN = 0, PAR_ODD = 1;
  - shared with the receiver for frame-format agreement.
- Sub-module uart_baud_cnt:
  - loadable down/up counter;
  - inputs CLK, RST, load, PRESCALE value;
  - output bit_done pulse on the final cycle of each bit period;
  - reused by the receiver's oversampling logic.

Test Plan:
- DATA_WIDTH=8, PRESCALE=0, PAR_EN=1, PAR_TYP=0, STOP2=0, P_DATA=0xA5 -> TX_OUT over 11 cycles = 0,1,0,1,0,0,1,0,1,0,1; Busy high for 11 cycles; DATA_READY high in the 11th.
- PRESCALE=3, PAR_EN=0, STOP2=1, P_DATA=0x0F -> each bit held 4 cycles; start 4 low, 16 high, 16 low, stop 8 high; 44-cycle frame.
- Back-to-back: DATA_VALID held, 0x55 then 0xAA, PRESCALE=1, PAR_EN=0 -> second start bit immediately follows first stop bit; zero idle cycles; exactly two accept pulses; Busy never drops.
- DATA_WIDTH=7, PAR_EN=1, PAR_TYP=1, P_DATA=0x7F, PRESCALE=0 -> 10-bit frame 0,1,1,1,1,1,1,1,0,1 (parity 0).
- RST=1 during the 4th data bit of 0xC3 -> TX_OUT=1, Busy=0 from the next edge; DATA_READY=1 after release; next word 0x01 sent cleanly.
- Change P_DATA, PRESCALE and PAR_TYP mid-frame -> current frame bit-exact to the captured values; new values apply only to the next accepted frame.
